// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC acquisition stage (state
// encoding, frame geometry and the offset-binary to two's-complement helper).
package adc_pkg;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        CONV   = 2'd1,
        LISTO  = 2'd2
    } estado_t;

    localparam int FRAME_BITS = 16;  // SCLK rising edges per conversion frame
    localparam int LEAD_BITS  = 4;   // leading zeros sent by the ADC, ignored
    localparam int ADC_W      = 12;  // converter resolution

    // Offset-binary to two's complement: inverting the MSB recentres the code on zero.
    function automatic logic [ADC_W-1:0] a_complemento2(input logic [ADC_W-1:0] crudo);
        return {~crudo[ADC_W-1], crudo[ADC_W-2:0]};
    endfunction

endpackage

// File: rtl/gen_tick_muestreo.sv
// gen_tick_muestreo: free-running sample-period counter 0..SAMPLE_DIV-1.
// tick_o is registered and high for exactly one cycle while the count sits at
// its terminal value.
module gen_tick_muestreo #(
    parameter int SAMPLE_DIV = 2268
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int            CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == TC) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter state and registered terminal-count flag (aligned with cnt_q == TC).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == TC);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/adc_muestreo.sv
// adc_muestreo: sample-rate tick, 16-clock serial read of a 12-bit ADC and
// conversion to a left-justified signed sample with a one-cycle datolisto strobe.
// Build option: define ADC_OVERRUN_EN to enable the sticky overrun flag
// (otherwise overrun is tied low and a tick during a conversion is simply ignored).
module adc_muestreo
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 2268,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdata,
    output logic             cs_n,
    output logic             sclk,
    output logic [OUT_W-1:0] muestra,
    output logic             datolisto,
    output logic             overrun
);

    localparam int              HC_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_TC     = HC_W'(CLK_DIV - 1);
    localparam int              FL_W      = $clog2(FRAME_BITS + 1);
    localparam logic [FL_W-1:0] FL_ULTIMO = FL_W'(FRAME_BITS - 1);

    logic                  tick_s;
    estado_t               estado_q;
    logic [HC_W-1:0]       hc_q;        // SCLK half-period counter
    logic [FL_W-1:0]       flancos_q;   // SCLK rising edges seen in this frame
    logic [FRAME_BITS-1:0] shift_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic [OUT_W-1:0]      muestra_q;
    logic                  datolisto_q;
    logic [FRAME_BITS-1:0] trama_s;     // frame including the bit sampled this cycle
    logic [OUT_W-1:0]      muestra_s;
    logic                  unused_bits_s;

    gen_tick_muestreo #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick_s)
    );

    // Formatter: the last bit is taken straight from sdata so the sample can be
    // registered on the same edge as the 16th SCLK rise. Leading bits are not checked.
    always_comb begin
        trama_s   = {shift_q[FRAME_BITS-2:0], sdata};
        muestra_s = '0;
        muestra_s[OUT_W-1 -: ADC_W] = a_complemento2(trama_s[ADC_W-1:0]);
    end

    // The oldest shifted bit is always one of the discarded leading bits.
    assign unused_bits_s = shift_q[FRAME_BITS-1];

    // Conversion FSM with SCLK divider, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q    <= ESPERA;
            hc_q        <= '0;
            flancos_q   <= '0;
            shift_q     <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            muestra_q   <= '0;
            datolisto_q <= 1'b0;
        end else begin
            datolisto_q <= 1'b0;
            case (estado_q)
                ESPERA: begin
                    cs_n_q    <= 1'b1;
                    sclk_q    <= 1'b1;
                    hc_q      <= '0;
                    flancos_q <= '0;
                    if (tick_s) begin
                        estado_q <= CONV;
                        cs_n_q   <= 1'b0;
                    end
                end
                CONV: begin
                    if (hc_q == HC_TC) begin
                        hc_q   <= '0;
                        sclk_q <= ~sclk_q;
                        // sclk going 0->1: sample sdata (ADC changed it on the fall)
                        if (!sclk_q) begin
                            shift_q   <= trama_s;
                            flancos_q <= flancos_q + FL_W'(1);
                            if (flancos_q == FL_ULTIMO) begin
                                estado_q    <= LISTO;
                                cs_n_q      <= 1'b1;
                                muestra_q   <= muestra_s;
                                datolisto_q <= 1'b1;
                            end
                        end
                    end else begin
                        hc_q <= hc_q + HC_W'(1);
                    end
                end
                LISTO: begin
                    // strobe cycle; sample and strobe were loaded on entry
                    estado_q <= ESPERA;
                    cs_n_q   <= 1'b1;
                    sclk_q   <= 1'b1;
                end
                default: begin
                    estado_q <= ESPERA;
                    cs_n_q   <= 1'b1;
                    sclk_q   <= 1'b1;
                end
            endcase
        end
    end

    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign muestra   = muestra_q;
    assign datolisto = datolisto_q;

`ifdef ADC_OVERRUN_EN
    logic overrun_q;

    // Sticky overrun: a tick outside ESPERA means the sample period is too short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (tick_s && (estado_q != ESPERA)) begin
            overrun_q <= 1'b1;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adc_muestreo.sv
// tb_adc_muestreo: directed bench for adc_muestreo (CLK_DIV=2, SAMPLE_DIV=100,
// OUT_W=16) plus a second instance with SAMPLE_DIV=50 for overrun behaviour.
module tb_adc_muestreo;

`ifdef ADC_OVERRUN_EN
    localparam logic OV_EXP = 1'b1;
`else
    localparam logic OV_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sdata = 1'b0;
    logic        cs_n, sclk, datolisto, overrun;
    logic [15:0] muestra;

    logic        reset50 = 1'b1;
    logic        cs_n50, sclk50, datolisto50, overrun50;
    logic [15:0] muestra50;

    int          checks = 0;
    int          failures = 0;

    logic [11:0] adc_code = 12'h800;
    logic [15:0] frame;
    int          idx = 0;

    always #5 clk = ~clk;

    adc_muestreo #(.CLK_DIV(2), .SAMPLE_DIV(100), .OUT_W(16)) dut (
        .clk(clk), .reset(reset), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
        .muestra(muestra), .datolisto(datolisto), .overrun(overrun)
    );

    adc_muestreo #(.CLK_DIV(2), .SAMPLE_DIV(50), .OUT_W(16)) dut50 (
        .clk(clk), .reset(reset50), .sdata(1'b1), .cs_n(cs_n50), .sclk(sclk50),
        .muestra(muestra50), .datolisto(datolisto50), .overrun(overrun50)
    );

    // ADC model: 4 zeros then 12 code bits MSB first, next bit driven on each SCLK fall.
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) begin
            idx = 0;
        end else if (idx < 16) begin
            frame = {4'b0000, adc_code};
            sdata = frame[15 - idx];
            idx   = idx + 1;
        end
    end

    task automatic ciclo();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic esperar_cs_bajada(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = cs_n;
        for (int i = 0; i < 300; i++) begin
            ciclo();
            if (prev && !cs_n) begin
                ok = 1'b1;
                break;
            end
            prev = cs_n;
        end
    endtask

    task automatic esperar_dato(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= 300; i++) begin
            ciclo();
            if (datolisto) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        reset50 = 1'b1;
        repeat (3) ciclo();
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
        checks++; if (muestra !== 16'h0000) begin failures++; $display("FAIL reset_muestra got=%h exp=0000", muestra); end
        checks++; if (datolisto !== 1'b0) begin failures++; $display("FAIL reset_datolisto got=%b exp=0", datolisto); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (overrun50 !== 1'b0) begin failures++; $display("FAIL reset_overrun50 got=%b exp=0", overrun50); end
        reset   = 1'b0;
        reset50 = 1'b0;
    endtask

    // First frame after reset: tick after 99 clocks, datolisto 65 clocks later.
    task automatic test_latency();
        adc_code = 12'h800;
        for (int k = 1; k <= 170; k++) begin
            ciclo();
            if (k == 99) begin checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL lat_cs_n_k99 got=%b exp=1", cs_n); end end
            if (k == 100) begin checks++; if (cs_n !== 1'b0) begin failures++; $display("FAIL lat_cs_n_k100 got=%b exp=0", cs_n); end end
            if (k == 101) begin checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL lat_sclk_k101 got=%b exp=1", sclk); end end
            if (k == 102) begin checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL lat_sclk_k102 got=%b exp=0", sclk); end end
            if (k == 163) begin checks++; if (datolisto !== 1'b0 || cs_n !== 1'b0) begin failures++; $display("FAIL lat_k163 got dl=%b cs_n=%b exp dl=0 cs_n=0", datolisto, cs_n); end end
            if (k == 164) begin checks++; if (datolisto !== 1'b1 || cs_n !== 1'b1) begin failures++; $display("FAIL lat_k164 got dl=%b cs_n=%b exp dl=1 cs_n=1", datolisto, cs_n); end end
            if (k == 164) begin checks++; if (muestra !== 16'h0000) begin failures++; $display("FAIL lat_muestra_800 got=%h exp=0000", muestra); end end
            if (k == 165) begin checks++; if (datolisto !== 1'b0) begin failures++; $display("FAIL lat_width got=%b exp=0", datolisto); end end
        end
    endtask

    // SAMPLE_DIV=50 instance, sdata tied high (code 0xFFF): ticks at 49,99,149,...
    task automatic test_overrun();
        int pulses = 0;
        for (int k = 1; k <= 400; k++) begin
            ciclo();
            if (datolisto50) pulses++;
            if (k == 99) begin checks++; if (overrun50 !== 1'b0) begin failures++; $display("FAIL ov_before_2nd_tick got=%b exp=0", overrun50); end end
            if (k == 100) begin checks++; if (overrun50 !== OV_EXP) begin failures++; $display("FAIL ov_after_2nd_tick got=%b exp=%b", overrun50, OV_EXP); end end
            if (k == 114) begin checks++; if (datolisto50 !== 1'b1 || cs_n50 !== 1'b1 || sclk50 !== 1'b1) begin failures++; $display("FAIL ov_frame1_done got dl=%b cs_n=%b sclk=%b exp 1 1 1", datolisto50, cs_n50, sclk50); end end
            if (k == 400) begin checks++; if (overrun50 !== OV_EXP) begin failures++; $display("FAIL ov_sticky got=%b exp=%b", overrun50, OV_EXP); end end
        end
        checks++; if (pulses !== 3) begin failures++; $display("FAIL ov_frame_count got=%0d exp=3", pulses); end
        checks++; if (muestra50 !== 16'h7FF0) begin failures++; $display("FAIL ov_muestra got=%h exp=7ff0", muestra50); end
    endtask

    // Codes 0xFFF then 0x000 in consecutive periods; muestra holds between strobes.
    task automatic test_back_to_back();
        bit ok;
        int n;
        int unstable = 0;
        int gap = 0;
        adc_code = 12'hFFF;
        esperar_cs_bajada(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_wait_cs got=timeout exp=frame start"); end
        esperar_dato(ok, n);
        checks++; if (!ok || muestra !== 16'h7FF0) begin failures++; $display("FAIL b2b_fff got=%h ok=%0d exp=7ff0", muestra, ok); end
        adc_code = 12'h000;
        for (int i = 1; i <= 150; i++) begin
            ciclo();
            if (datolisto) begin
                gap = i;
                break;
            end
            if (muestra !== 16'h7FF0) unstable++;
        end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL b2b_hold got=%0d changes exp=0", unstable); end
        checks++; if (gap !== 100) begin failures++; $display("FAIL b2b_period got=%0d exp=100", gap); end
        checks++; if (muestra !== 16'h8000) begin failures++; $display("FAIL b2b_000 got=%h exp=8000", muestra); end
    endtask

    // One frame: 16 rises while selected, 4-cycle period, sclk high when deselected.
    task automatic test_sclk_waveform();
        bit   ok;
        logic prev_sclk, prev_cs;
        int   rises = 0, bad_period = 0, bad_idle = 0, last = 0, ended = 0;
        esperar_cs_bajada(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wave_wait_cs got=timeout exp=frame start"); end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        for (int i = 1; i <= 100; i++) begin
            ciclo();
            if (!prev_sclk && sclk && !prev_cs) begin
                rises++;
                if (rises > 1 && (i - last) != 4) bad_period++;
                last = i;
            end
            if (cs_n && !sclk) bad_idle++;
            if (cs_n && !prev_cs) ended = i;
            prev_sclk = sclk;
            prev_cs   = cs_n;
        end
        checks++; if (rises !== 16) begin failures++; $display("FAIL wave_rises got=%0d exp=16", rises); end
        checks++; if (bad_period !== 0) begin failures++; $display("FAIL wave_period got=%0d bad exp=0", bad_period); end
        checks++; if (bad_idle !== 0 || ended == 0) begin failures++; $display("FAIL wave_idle got=%0d bad end=%0d exp=0 bad", bad_idle, ended); end
    endtask

    // Reset at the 8th SCLK edge of a frame, then a clean conversion of 0x5A3.
    task automatic test_reset_midframe();
        bit   ok;
        logic prev;
        int   edges = 0, first = 0;
        adc_code = 12'h5A3;
        esperar_cs_bajada(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_wait_cs got=timeout exp=frame start"); end
        prev = sclk;
        for (int i = 0; i < 100 && edges < 8; i++) begin
            ciclo();
            if (sclk != prev) edges++;
            prev = sclk;
        end
        reset = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1 || sclk !== 1'b1) begin failures++; $display("FAIL mid_reset_pins got cs_n=%b sclk=%b exp 1 1", cs_n, sclk); end
        checks++; if (datolisto !== 1'b0 || muestra !== 16'h0000) begin failures++; $display("FAIL mid_reset_data got dl=%b muestra=%h exp 0 0000", datolisto, muestra); end
        repeat (2) ciclo();
        reset = 1'b0;
        for (int k = 1; k <= 170; k++) begin
            ciclo();
            if (datolisto && first == 0) begin
                first = k;
                checks++; if (muestra !== 16'hDA30) begin failures++; $display("FAIL mid_recover_muestra got=%h exp=da30", muestra); end
            end
        end
        checks++; if (first !== 164) begin failures++; $display("FAIL mid_recover_latency got=%0d exp=164", first); end
    endtask

    initial begin
        test_reset();
        fork
            test_overrun();
            test_latency();
        join
        test_back_to_back();
        test_sclk_waveform();
        test_reset_midframe();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL main_overrun got=%b exp=0", overrun); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_muestreo.md
# adc_muestreo

Upstream acquisition stage of the audio equalizer: generates the sample-rate tick, runs a 16-clock serial read of a 12-bit ADC (4 leading zeros, 12 data bits MSB first), and converts the raw offset-binary code to a left-justified two's-complement sample. Presents the sample with a one-cycle `datolisto` strobe, which starts the arithmetic-unit control sequence.

## Interface
- `CLK_DIV`, 2, clk cycles per SCLK half-period (≥1)
- `SAMPLE_DIV`, 2268, clk cycles per sample period; must exceed 32·CLK_DIV+4
- `OUT_W`, 16, width of `muestra` (≥12)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `sdata`  in  1  ADC serial data (ADC drives it on SCLK falling edge)
- `cs_n`  out  1  ADC chip select, active-low
- `sclk`  out  1  ADC serial clock, idles high
- `muestra`  out  OUT_W  signed sample, held until next conversion completes
- `datolisto`  out  1  one-cycle strobe, `muestra` valid
- `overrun`  out  1  sticky: sample tick arrived while a conversion was in progress

## Operation
- Reset values: `cs_n`=1, `sclk`=1, `muestra`=0, `datolisto`=0, `overrun`=0; tick counter=0; FSM=ESPERA.
- Tick counter free-runs 0..SAMPLE_DIV-1; `tick` is high for one cycle at terminal count. It is independent of the FSM.
- FSM states:
  - ESPERA: `cs_n`=1, `sclk`=1. On `tick` → CONV.
  - CONV: `cs_n`=0. Half-period counter 0..CLK_DIV-1; `sclk` toggles at terminal count. On each SCLK rising edge (the clk cycle in which `sclk` goes 0→1), `sdata` is shifted into a 16-bit register. After the 16th rising edge → LISTO.
  - LISTO: `cs_n`=1, `sclk`=1. Registers `muestra`, pulses `datolisto`, → ESPERA.
- Format: raw = bits 5..16 of the frame (bits 1..4 discarded, not checked). `muestra` = {~raw[11], raw[10:0], (OUT_W-12) zeros}. Examples for OUT_W=16: 0x800→0x0000, 0xFFF→0x7FF0, 0x000→0x8000.
- `tick` in CONV or LISTO: ignored (no restart, no frame loss); sets `overrun`. Only reset clears `overrun`.
- `reset` mid-frame: all outputs return to their reset values at once. A partial frame is discarded.

## Timing
- `tick` at cycle T → `cs_n` falls at T+1 → first `sclk` fall at T+1+CLK_DIV → 16th rising edge at T+32·CLK_DIV → `cs_n` rises and `datolisto`=1 at T+1+32·CLK_DIV (`muestra` is valid in the same cycle).
- Latency is 32·CLK_DIV+1 cycles from `tick` to `datolisto`. `datolisto` is high for exactly 1 cycle.
- `muestra` changes only in the `datolisto` cycle.
- All outputs are registered. `sdata` is sampled directly. The board-level synchronizer is outside this block.

## Configuration
- `ADC_OVERRUN_EN` defined: overrun detection as described above.
- Not defined: `overrun` is tied to 0, the detection logic is removed, and a tick during a conversion is still ignored.

## Structure
- Shared package `adc_pkg`:
  - state encoding (ESPERA, CONV, LISTO)
  - FRAME_BITS=16, LEAD_BITS=4, ADC_W=12
- One sub-module `gen_tick_muestreo`: parameterized SAMPLE_DIV counter with a `tick` output and async reset.
- SCLK divider, shift register and formatter stay in the top module.

## Test plan
Settings: CLK_DIV=2, SAMPLE_DIV=100, OUT_W=16. The bench ADC model drives `sdata` on SCLK falling edges.
- ADC code 0x800 → `muestra`=0x0000; `datolisto` exactly 65 cycles after `tick`, width 1.
- ADC codes 0xFFF then 0x000 in consecutive periods → 0x7FF0 then 0x8000. `muestra` is stable between strobes.
- Count SCLK and check waveform per frame: exactly 16 rising edges with `cs_n`=0; SCLK period 4 cycles; `sclk`=1 whenever `cs_n`=1.
- Assert `reset` at the 8th SCLK edge of a frame → `cs_n`=1, `sclk`=1, `datolisto`=0 and `muestra`=0 at once. After release, the next frame converts correctly.
- SAMPLE_DIV=50 with `ADC_OVERRUN_EN`: `overrun` rises on the 2nd tick and stays 1, and frames still complete. Without the macro, `overrun` stays 0.
